// File: rtl/secure_key_fetch_if.sv
// Request/response handshake and secure_memory bus bundle for secure_key_fetch.
// Ports:
//   slave  : view taken by secure_key_fetch. It receives requests and lc_state, and it
//            drives the responses and the memory strobes.
//   master : view taken by the requester and the memory model, with the opposite directions.
// Parameters: WIDTH (data word width), ADDR_W (slot index width).
interface secure_key_fetch_if #(
  parameter int unsigned WIDTH  = 256,
  parameter int unsigned ADDR_W = 3
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_slot;
  logic [WIDTH-1:0]  req_wdata;
  logic [1:0]        lc_state;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WIDTH-1:0]  rsp_data;
  logic [1:0]        rsp_err;
  logic              mem_rd_en;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_wrData;
  logic [WIDTH-1:0]  mem_rdData;
  logic              mem_rdData_valid;
  logic              busy;

  modport slave (
    input  req_valid, req_write, req_slot, req_wdata, lc_state, rsp_ready,
           mem_rdData, mem_rdData_valid,
    output req_ready, rsp_valid, rsp_data, rsp_err, mem_rd_en, mem_wr_en,
           mem_addr, mem_wrData, busy
  );

  modport master (
    output req_valid, req_write, req_slot, req_wdata, lc_state, rsp_ready,
           mem_rdData, mem_rdData_valid,
    input  req_ready, rsp_valid, rsp_data, rsp_err, mem_rd_en, mem_wr_en,
           mem_addr, mem_wrData, busy
  );
endinterface

// File: rtl/secure_key_fetch.sv
// Policy-checked access front-end for secure_memory.
// The block takes one read or write request at a time and checks it against a snapshot
// of the lifecycle state. It then drives the memory strobes and returns the data or an
// error code. Key data is cleared from rsp_data after the response handshake.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous reset, active-high
//   bus : secure_key_fetch_if.slave. It carries:
//           - req_* valid/ready request, and lc_state
//           - rsp_* valid/ready response with data and a 2-bit error code
//                   (00 ok, 01 denied, 10 timeout)
//           - mem_* secure_memory strobes and read-back
//           - busy, which is high whenever the block is not IDLE
// Every output comes from a register.
module secure_key_fetch #(
  parameter int unsigned WIDTH   = 256,
  parameter int unsigned LENGTH  = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  secure_key_fetch_if.slave  bus
);

  localparam int unsigned ADDR_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam int unsigned CNT_W  = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_DENIED  = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    RD    = 3'd2,
    WR    = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t            state_q, state_d;

  // Request captured at acceptance
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] slot_q, slot_d;
  logic [WIDTH-1:0]  wdata_q, wdata_d;
  logic [1:0]        lc_q, lc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Output registers
  logic              req_ready_q, req_ready_d;
  logic              busy_q, busy_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;
  logic [1:0]        rsp_err_q, rsp_err_d;
  logic              mem_rd_en_q, mem_rd_en_d;
  logic              mem_wr_en_q, mem_wr_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0]  mem_wdata_q, mem_wdata_d;

  logic              allowed;
  logic              rd_hit;

  // Access policy: slot map against the lifecycle snapshot
  function automatic logic policy_ok(input logic w, input logic [ADDR_W-1:0] s,
                                     input logic [1:0] lc);
    logic ok;
    ok = 1'b0;
    if (lc == 2'd3) begin
      ok = !w && (32'(s) == 32'd0);
    end else if (w) begin
      ok = (lc == 2'd0) && (32'(s) <= 32'd1);
    end else if (32'(s) <= 32'd1) begin
      ok = 1'b1;
    end else if (32'(s) == 32'd2) begin
      ok = (lc == 2'd1) || (lc == 2'd2);
    end else if (32'(s) == 32'd3) begin
      ok = (lc == 2'd2);
    end else begin
      // Owner-ID slots are bound one-to-one to the lifecycle phase
      ok = (32'(s) == (32'd4 + 32'(lc)));
    end
    return ok;
  endfunction

  assign allowed = policy_ok(wr_q, slot_q, lc_q);
  // A valid seen in the first RD cycle is left over from an earlier read
  assign rd_hit  = bus.mem_rdData_valid && (cnt_q != '0);

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    slot_d      = slot_q;
    wdata_d     = wdata_q;
    lc_d        = lc_q;
    cnt_d       = cnt_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          wr_d    = bus.req_write;
          slot_d  = bus.req_slot;
          wdata_d = bus.req_write ? bus.req_wdata : '0;
          lc_d    = bus.lc_state;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (!allowed) begin
          rsp_err_d  = ERR_DENIED;
          rsp_data_d = '0;
          state_d    = RESP;
        end else if (wr_q) begin
          state_d = WR;
        end else begin
          cnt_d   = '0;
          state_d = RD;
        end
      end
      WR: begin
        rsp_err_d  = ERR_OK;
        rsp_data_d = '0;
        state_d    = RESP;
      end
      RD: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (rd_hit) begin
          rsp_data_d = bus.mem_rdData;
          rsp_err_d  = ERR_OK;
          state_d    = RESP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_data_d = '0;
          rsp_err_d  = ERR_TIMEOUT;
          state_d    = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          // Scrub the key material and the write data once the consumer has taken them
          rsp_data_d = '0;
          rsp_err_d  = ERR_OK;
          wdata_d    = '0;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The outputs are decoded from the next state, so each one is valid in the same
    // cycle as the state it belongs to.
    req_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    rsp_valid_d = (state_d == RESP);
    mem_rd_en_d = (state_d == RD);
    mem_wr_en_d = (state_d == WR);
    mem_addr_d  = ((state_d == RD) || (state_d == WR)) ? slot_q : '0;
    mem_wdata_d = (state_d == WR) ? wdata_q : '0;
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_q        <= 1'b0;
      slot_q      <= '0;
      wdata_q     <= '0;
      lc_q        <= '0;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= '0;
      mem_rd_en_q <= 1'b0;
      mem_wr_en_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      slot_q      <= slot_d;
      wdata_q     <= wdata_d;
      lc_q        <= lc_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      mem_rd_en_q <= mem_rd_en_d;
      mem_wr_en_q <= mem_wr_en_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.busy       = busy_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.mem_rd_en  = mem_rd_en_q;
  assign bus.mem_wr_en  = mem_wr_en_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wrData = mem_wdata_q;

  // Memory strobe invariants
  a_excl_en: assert property (@(posedge clk) disable iff (rst)
    !(mem_rd_en_q && mem_wr_en_q));
  a_idle_bus: assert property (@(posedge clk) disable iff (rst)
    (!mem_rd_en_q && !mem_wr_en_q) |-> (mem_addr_q == '0 && mem_wdata_q == '0));

endmodule

// File: tb/tb_secure_key_fetch.sv
// Self-checking bench for secure_key_fetch. It uses a table of directed requests and
// some hand-written sequences for the timeout, stale-valid and reset cases.
module tb_secure_key_fetch;

  localparam int unsigned WIDTH   = 256;
  localparam int unsigned LENGTH  = 8;
  localparam int unsigned ADDR_W  = 3;
  localparam int unsigned TIMEOUT = 16;

  localparam logic [255:0] KEY3  = 256'h3F7A_1C2B_9D4E_8F60_1A2B_3C4D_5E6F_7081_92A3_B4C5_D6E7_F809_1B2C_3D4E_5F60_596D;
  localparam logic [255:0] A5W   = {32{8'hA5}};
  localparam logic [255:0] STALE = {8{32'hDEAD_BEEF}};

  localparam int M_NORMAL = 0;
  localparam int M_NEVER  = 1;
  localparam int M_STALE  = 2;

  logic clk;
  logic rst;
  int   mem_mode;
  int   n_tests;
  int   n_fail;

  secure_key_fetch_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  secure_key_fetch #(.WIDTH(WIDTH), .LENGTH(LENGTH), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] slot_init(input int i);
    if (i == 3) return KEY3;
    return {8{32'hC0DE_0000 | 32'(i)}};
  endfunction

  // Memory model: read data and valid appear one cycle after rd_en
  logic [255:0] mem [8];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) mem[i] <= slot_init(i);
      bus.mem_rdData       <= '0;
      bus.mem_rdData_valid <= 1'b0;
    end else begin
      if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wrData;
      if (mem_mode == M_NEVER) begin
        bus.mem_rdData_valid <= 1'b0;
      end else if (bus.mem_rd_en) begin
        bus.mem_rdData       <= mem[bus.mem_addr];
        bus.mem_rdData_valid <= 1'b1;
      end else if (mem_mode == M_STALE) begin
        bus.mem_rdData       <= STALE;
        bus.mem_rdData_valid <= 1'b1;
      end else begin
        bus.mem_rdData_valid <= 1'b0;
      end
    end
  end

  typedef struct {
    logic         write;
    logic [2:0]   slot;
    logic [1:0]   lc;
    logic [1:0]   lc_after;
    logic [255:0] wdata;
    logic [1:0]   exp_err;
    logic [255:0] exp_data;
    int           exp_lat;
    int           exp_rd;
    int           exp_wr;
  } vec_t;

  function automatic vec_t mk(input logic w, input int s, input int lc, input int lca,
                              input logic [255:0] wd, input int err, input logic [255:0] d,
                              input int lat, input int rd, input int wr);
    vec_t v;
    v.write = w; v.slot = 3'(s); v.lc = 2'(lc); v.lc_after = 2'(lca); v.wdata = wd;
    v.exp_err = 2'(err); v.exp_data = d; v.exp_lat = lat; v.exp_rd = rd; v.exp_wr = wr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request, follow it to the response, then complete the handshake
  task automatic run_req(input vec_t v, input string tag);
    int lat;
    int rd_cnt;
    int wr_cnt;
    int bad;
    bit seen;
    logic [255:0] d;
    logic [1:0]   e;
    rd_cnt = 0; wr_cnt = 0; bad = 0; seen = 1'b0; lat = 0;
    @(negedge clk);
    chk({tag, " req_ready"}, 256'(bus.req_ready), 256'(1));
    bus.req_valid = 1'b1;
    bus.req_write = v.write;
    bus.req_slot  = v.slot;
    bus.req_wdata = v.wdata;
    bus.lc_state  = v.lc;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_wdata = '0;
    bus.lc_state  = v.lc_after;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge clk);
      lat = k;
      if (!bus.busy || bus.req_ready) bad++;
      if (bus.mem_rd_en && bus.mem_wr_en) bad++;
      if (bus.mem_rd_en) begin
        rd_cnt++;
        if (bus.mem_addr !== v.slot) bad++;
      end
      if (bus.mem_wr_en) begin
        wr_cnt++;
        if (bus.mem_addr !== v.slot || bus.mem_wrData !== v.wdata) bad++;
      end
      if (!bus.mem_rd_en && !bus.mem_wr_en && (bus.mem_addr !== '0 || bus.mem_wrData !== '0)) bad++;
      if (bus.rsp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) lat = 99;
    d = bus.rsp_data;
    e = bus.rsp_err;
    chk({tag, " latency"}, 256'(lat), 256'(v.exp_lat));
    chk({tag, " err"}, 256'(e), 256'(v.exp_err));
    chk({tag, " data"}, d, v.exp_data);
    chk({tag, " rd_en cycles"}, 256'(rd_cnt), 256'(v.exp_rd));
    chk({tag, " wr_en cycles"}, 256'(wr_cnt), 256'(v.exp_wr));
    chk({tag, " bus protocol errors"}, 256'(bad), 256'(0));
    if (seen) begin
      @(negedge clk);
      chk({tag, " rsp held"}, {253'(0), bus.rsp_valid, bus.rsp_err}, {253'(0), 1'b1, v.exp_err});
      chk({tag, " data held"}, bus.rsp_data, v.exp_data);
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      chk({tag, " rsp dropped"}, 256'(bus.rsp_valid), 256'(0));
      chk({tag, " data scrubbed"}, bus.rsp_data, 256'(0));
      chk({tag, " back to idle"}, {254'(0), bus.req_ready, bus.busy}, {254'(0), 1'b1, 1'b0});
    end
  endtask

  vec_t vecs [15];

  initial begin
    vecs[0]  = mk(1'b0, 3, 2, 2, '0,  0, KEY3,         4, 2, 0);
    vecs[1]  = mk(1'b0, 3, 1, 1, '0,  1, '0,           2, 0, 0);
    vecs[2]  = mk(1'b1, 1, 0, 0, A5W, 0, '0,           3, 0, 1);
    vecs[3]  = mk(1'b0, 1, 0, 0, '0,  0, A5W,          4, 2, 0);
    vecs[4]  = mk(1'b1, 1, 2, 2, A5W, 1, '0,           2, 0, 0);
    vecs[5]  = mk(1'b0, 0, 3, 3, '0,  0, slot_init(0), 4, 2, 0);
    vecs[6]  = mk(1'b0, 1, 3, 3, '0,  1, '0,           2, 0, 0);
    vecs[7]  = mk(1'b0, 2, 1, 1, '0,  0, slot_init(2), 4, 2, 0);
    vecs[8]  = mk(1'b0, 2, 0, 0, '0,  1, '0,           2, 0, 0);
    vecs[9]  = mk(1'b0, 5, 1, 1, '0,  0, slot_init(5), 4, 2, 0);
    vecs[10] = mk(1'b0, 6, 1, 1, '0,  1, '0,           2, 0, 0);
    vecs[11] = mk(1'b0, 7, 3, 3, '0,  1, '0,           2, 0, 0);
    vecs[12] = mk(1'b1, 2, 0, 0, A5W, 1, '0,           2, 0, 0);
    vecs[13] = mk(1'b0, 4, 0, 3, '0,  0, slot_init(4), 4, 2, 0);
    vecs[14] = mk(1'b0, 2, 2, 0, '0,  0, slot_init(2), 4, 2, 0);

    n_tests = 0;
    n_fail  = 0;
    mem_mode = M_NORMAL;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_slot  = '0;
    bus.req_wdata = '0;
    bus.lc_state  = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset ready/busy/valid", {253'(0), bus.req_ready, bus.busy, bus.rsp_valid}, {253'(0), 3'b100});
    chk("reset rsp_data/err", bus.rsp_data | 256'(bus.rsp_err), 256'(0));
    chk("reset mem strobes", {253'(0), bus.mem_rd_en, bus.mem_wr_en, |bus.mem_addr}, 256'(0));
    chk("reset mem_wrData", bus.mem_wrData, 256'(0));
    rst = 1'b0;

    // An early rsp_ready with no response pending must not change anything
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("idle rsp_ready ignored", {253'(0), bus.rsp_valid, bus.req_ready, bus.busy}, {253'(0), 3'b010});

    for (int i = 0; i < 15; i++) run_req(vecs[i], $sformatf("vec%0d", i));

    // Memory never answers, so the request times out
    mem_mode = M_NEVER;
    run_req(mk(1'b0, 0, 0, 0, '0, 2, '0, 2 + TIMEOUT, TIMEOUT, 0), "timeout");
    mem_mode = M_NORMAL;

    // Valid is already high on entry to RD and carries stale data
    mem_mode = M_STALE;
    @(negedge clk);
    chk("stale valid preset", 256'(bus.mem_rdData_valid), 256'(1));
    run_req(mk(1'b0, 2, 2, 2, '0, 0, slot_init(2), 4, 2, 0), "stale");
    mem_mode = M_NORMAL;

    // Reset mid-read with rsp_ready held low
    mem_mode = M_NEVER;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_slot  = 3'd0;
    bus.lc_state  = 2'd0;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid-read rd_en", 256'(bus.mem_rd_en), 256'(1));
    rst = 1'b1;
    #1;
    chk("async reset drops rd_en", 256'(bus.mem_rd_en), 256'(0));
    chk("async reset ready/busy", {254'(0), bus.req_ready, bus.busy}, {254'(0), 2'b10});
    @(negedge clk);
    rst = 1'b0;
    mem_mode = M_NORMAL;
    run_req(mk(1'b0, 3, 2, 1, '0, 0, KEY3, 4, 2, 0), "after reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
